// File: rtl/pipelined_cla_adder.sv
// Pipelined CLA add/sub: one SEG-bit segment per stage, built from BLOCK-bit look-ahead groups.
// Latency STAGES cycles at 1 op/cycle; the whole pipe holds while out_valid & !out_ready.
module pipelined_cla_adder #(
   parameter int WIDTH  = 32,
   parameter int BLOCK  = 4,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int SEG  = WIDTH / STAGES;
   localparam int GRPS = SEG / BLOCK;
   localparam int NP   = (STAGES > 1) ? STAGES - 1 : 1;

   if (STAGES < 1 || (WIDTH % (STAGES * BLOCK)) != 0) begin : g_param_check
      $error("pipelined_cla_adder: WIDTH must be a multiple of STAGES*BLOCK");
   end

   // Carry look-ahead group: every carry is a flat sum of generate/propagate products.
   function automatic logic [BLOCK:0] cla_group(input logic [BLOCK-1:0] x,
                                                input logic [BLOCK-1:0] y,
                                                input logic             ci);
      logic [BLOCK-1:0] g;
      logic [BLOCK-1:0] p;
      logic [BLOCK:0]   c;
      logic             term;
      g    = x & y;
      p    = x ^ y;
      c    = '0;
      c[0] = ci;
      for (int i = 0; i < BLOCK; i++) begin
         term = ci;
         for (int m = 0; m <= i; m++) term = term & p[m];
         c[i+1] = term;
         for (int j = 0; j <= i; j++) begin
            term = g[j];
            for (int m = j + 1; m <= i; m++) term = term & p[m];
            c[i+1] = c[i+1] | term;
         end
      end
      return {c[BLOCK], p ^ c[BLOCK-1:0]};
   endfunction

   logic              adv;
   logic [STAGES-1:0] vld_q, vld_d;
   logic [WIDTH-1:0]  sum_q [STAGES];
   logic [WIDTH-1:0]  sum_d [STAGES];
   logic [WIDTH-1:0]  opa_q [NP];
   logic [WIDTH-1:0]  opa_d [NP];
   logic [WIDTH-1:0]  opb_q [NP];
   logic [WIDTH-1:0]  opb_d [NP];
   logic [NP-1:0]     cry_q, cry_d;
   logic              cout_q, cout_d;
   logic              ovf_q, ovf_d;
   logic              zero_q, zero_d;

   logic              src_v, src_c, carry;
   logic [WIDTH-1:0]  src_a, src_b, src_s;
   logic [BLOCK:0]    grp;

   assign adv      = !vld_q[STAGES-1] || out_ready;
   assign in_ready = adv;

   always_comb begin
      vld_d  = vld_q;
      sum_d  = sum_q;
      opa_d  = opa_q;
      opb_d  = opb_q;
      cry_d  = cry_q;
      cout_d = cout_q;
      ovf_d  = ovf_q;
      zero_d = zero_q;
      src_v  = 1'b0;
      src_c  = 1'b0;
      src_a  = '0;
      src_b  = '0;
      src_s  = '0;
      carry  = 1'b0;
      grp    = '0;
      for (int k = 0; k < STAGES; k++) begin
         int kin;
         int kout;
         kin  = (k > 0) ? k - 1 : 0;
         kout = (k < STAGES - 1) ? k : 0;
         if (k == 0) begin
            src_v = in_valid;
            src_a = a;
            src_b = sub ? ~b : b;
            src_c = sub;
            src_s = '0;
         end else begin
            src_v = vld_q[kin];
            src_a = opa_q[kin];
            src_b = opb_q[kin];
            src_c = cry_q[kin];
            src_s = sum_q[kin];
         end
         carry = src_c;
         for (int g = 0; g < GRPS; g++) begin
            grp = cla_group(src_a[k*SEG + g*BLOCK +: BLOCK], src_b[k*SEG + g*BLOCK +: BLOCK], carry);
            src_s[k*SEG + g*BLOCK +: BLOCK] = grp[BLOCK-1:0];
            carry = grp[BLOCK];
         end
         vld_d[k] = src_v;
         // Data registers only load on a real op so bubbles never disturb held results.
         if (src_v) begin
            sum_d[k] = src_s;
            if (k < STAGES - 1) begin
               opa_d[kout] = src_a;
               opb_d[kout] = src_b;
               cry_d[kout] = carry;
            end else begin
               cout_d = carry;
               ovf_d  = carry ^ (src_s[WIDTH-1] ^ src_a[WIDTH-1] ^ src_b[WIDTH-1]);
               zero_d = ~|src_s;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q  <= '0;
         sum_q  <= '{default: '0};
         opa_q  <= '{default: '0};
         opb_q  <= '{default: '0};
         cry_q  <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else if (adv) begin
         vld_q  <= vld_d;
         sum_q  <= sum_d;
         opa_q  <= opa_d;
         opb_q  <= opb_d;
         cry_q  <= cry_d;
         cout_q <= cout_d;
         ovf_q  <= ovf_d;
         zero_q <= zero_d;
      end
   end

   assign out_valid = vld_q[STAGES-1];
   assign sum       = sum_q[STAGES-1];
   assign cout      = cout_q;
   assign ovf       = ovf_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: directed corner cases, stall, reset flush and random traffic
// checked by a scoreboard fed from an arithmetic A+/-B reference model.
module tb_pipelined_cla_adder;

   localparam int W   = 32;
   localparam int BLK = 4;
   localparam int STG = 2;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;
   logic         zero;

   always #5 clk = ~clk;

   pipelined_cla_adder #(.WIDTH(W), .BLOCK(BLK), .STAGES(STG)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .zero      (zero)
   );

   typedef struct {
      logic [31:0] x;
      logic [31:0] y;
      logic        op;
      logic [31:0] s;
      logic        c;
      logic        o;
      logic        z;
      longint      adv;
   } exp_t;

   exp_t         q[$];
   exp_t         mon_e;
   int           checks = 0;
   int           errors = 0;
   longint       adv_cnt = 0;
   logic         held = 1'b0;
   logic [W-1:0] held_s;
   logic [2:0]   held_f;

   // Reference: plain wide arithmetic; signed overflow = exact result outside 32-bit range.
   function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic s);
      exp_t            r;
      longint          sx, sy, ex;
      longint unsigned ux, uy;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'b0, x};
      uy = {32'b0, y};
      r.x = x;
      r.y = y;
      r.op = s;
      if (s) begin
         r.s = x - y;
         r.c = (ux >= uy);
         ex  = sx - sy;
      end else begin
         r.s = x + y;
         r.c = ((ux + uy) >> 32) != 0;
         ex  = sx + sy;
      end
      r.o = (ex > 64'sd2147483647) || (ex < -64'sd2147483648);
      r.z = (r.s == 32'd0);
      r.adv = 0;
      return r;
   endfunction

   // Scoreboard monitor, sampling on the falling edge.
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         held = 1'b0;
      end else begin
         checks++;
         if (in_ready !== (!out_valid || out_ready)) begin
            errors++;
            $display("FAIL in_ready_rule: got %b with out_valid=%b out_ready=%b", in_ready, out_valid, out_ready);
         end
         if (held) begin
            checks++;
            if (out_valid !== 1'b1 || sum !== held_s || {cout, ovf, zero} !== held_f) begin
               errors++;
               $display("FAIL stall_hold: got v=%b sum=%h flags=%b, required v=1 sum=%h flags=%b",
                        out_valid, sum, {cout, ovf, zero}, held_s, held_f);
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_result: got sum=%h with no op outstanding", sum);
            end else begin
               mon_e = q.pop_front();
               if (sum !== mon_e.s || cout !== mon_e.c || ovf !== mon_e.o || zero !== mon_e.z ||
                   (adv_cnt - mon_e.adv) != STG) begin
                  errors++;
                  $display("FAIL result %h %s %h: got sum=%h c=%b o=%b z=%b lat=%0d, required sum=%h c=%b o=%b z=%b lat=%0d",
                           mon_e.x, mon_e.op ? "-" : "+", mon_e.y, sum, cout, ovf, zero, adv_cnt - mon_e.adv,
                           mon_e.s, mon_e.c, mon_e.o, mon_e.z, STG);
               end
            end
         end
         if (in_valid && in_ready) begin
            mon_e = model(a, b, sub);
            mon_e.adv = adv_cnt;
            q.push_back(mon_e);
         end
         if (!out_valid || out_ready) adv_cnt++;
         held   = out_valid && !out_ready;
         held_s = sum;
         held_f = {cout, ovf, zero};
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, got, exp);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 just after the op was accepted.
   task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic s);
      bit ok;
      ok = 1'b0;
      in_valid = 1'b1;
      a = x;
      b = y;
      sub = s;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL drive_timeout: in_ready stayed 0 for 100 cycles, required 1");
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = $urandom;
      b = $urandom;
      sub = 1'($urandom_range(0, 1));
   endtask

   task automatic dir_check(input string name, input logic [31:0] x, input logic [31:0] y, input logic s,
                            input logic [31:0] es, input logic ec, input logic eo, input logic ez);
      drive(x, y, s);
      for (int i = 1; i < STG; i++) begin
         @(negedge clk);
         chk({name, "_early_valid"}, 32'(out_valid), 32'd0);
      end
      @(negedge clk);
      chk({name, "_valid"}, 32'(out_valid), 32'd1);
      chk({name, "_sum"}, sum, es);
      chk({name, "_flags_c_o_z"}, 32'({cout, ovf, zero}), 32'({ec, eo, ez}));
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         4: return 32'h0000_0001;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int acc;
      bit drained;
      rst = 1'b1;
      in_valid = 1'b0;
      a = '0;
      b = '0;
      sub = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_sum", sum, 32'd0);
      chk("reset_flags", 32'({cout, ovf, zero}), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_reset_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;

      dir_check("add_wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
      dir_check("add_ovf",  32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
      dir_check("sub_neg",  32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
      dir_check("sub_pos",  32'd7, 32'd5, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
      dir_check("sub_ovf",  32'h8000_0000, 32'h1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

      // Back-to-back ops with the sink stalled for four cycles.
      fork
         begin
            drive(32'd1, 32'd1, 1'b0);
            drive(32'd2, 32'd2, 1'b0);
            drive(32'd3, 32'd3, 1'b0);
            drive(32'd4, 32'd4, 1'b0);
         end
         begin
            repeat (2) @(posedge clk);
            #1 out_ready = 1'b0;
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 32'(!out_valid));
            repeat (4) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      repeat (8) @(negedge clk);
      chk("stall_all_delivered", 32'(q.size()), 32'd0);
      @(posedge clk);
      #1;

      // Reset with two ops in flight.
      drive(32'd11, 32'd22, 1'b0);
      drive(32'd33, 32'd44, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rst_flush_out_valid", 32'(out_valid), 32'd0);
      end
      @(posedge clk);
      #1;
      dir_check("after_rst", 32'd9, 32'd9, 1'b0, 32'd18, 1'b0, 1'b0, 1'b0);

      // Random traffic with random source and sink pacing.
      acc = 0;
      for (int cyc = 0; cyc < 60000 && acc < 10000; cyc++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         a         = pick();
         b         = pick();
         sub       = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 9) < 7);
         @(negedge clk);
         if (in_valid && in_ready) acc++;
         @(posedge clk);
         #1;
      end
      chk("random_ops_accepted", 32'(acc), 32'd10000);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drained = 1'b0;
      for (int i = 0; i < 50 && !drained; i++) begin
         @(negedge clk);
         drained = (q.size() == 0);
      end
      chk("random_drain", 32'(q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #5000000;
      errors++;
      $display("FAIL watchdog: run did not end within time limit");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
